// File: rtl/dds_phase_gen_if.sv
// DDS generator bus: tuning/config inputs, quarter-wave ROM port and sample outputs.
// Latency: none, pure wiring.
// Backpressure: none, the generator streams one sample per clock.
interface dds_phase_gen_if #(
    parameter int ACC_W  = 32,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
);
    logic              en;
    logic [ACC_W-1:0]  f_word;
    logic [ACC_W-1:0]  p_word;
    logic [1:0]        wave_sel;
    logic [ADDR_W-3:0] rom_addr;
    logic [DATA_W-2:0] rom_data;
    logic [DATA_W-1:0] wave_out;
    logic              wave_valid;
    logic              sync_pulse;

    // Environment side: drives configuration, owns the sine ROM, consumes samples.
    modport master (
        output en, f_word, p_word, wave_sel, rom_data,
        input  rom_addr, wave_out, wave_valid, sync_pulse
    );

    // Generator side.
    modport slave (
        input  en, f_word, p_word, wave_sel, rom_data,
        output rom_addr, wave_out, wave_valid, sync_pulse
    );
endinterface

// File: rtl/dds_phase_gen.sv
// Phase-accumulator waveform generator (sine/square/triangle/saw) driving a quarter-wave sync ROM.
// Latency: accumulator value registered at clk n appears on wave_out at clk n+3.
// Backpressure: none; tuning changes are shadowed and applied only at an accumulator wrap.
module dds_phase_gen #(
    parameter int ACC_W  = 32,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    dds_phase_gen_if.slave dds
);

    localparam logic [DATA_W-1:0] MID = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

    // Accumulator and active (shadowed) parameters
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ACC_W-1:0]  f_act_q, f_act_d;
    logic [ACC_W-1:0]  p_act_q, p_act_d;
    logic [1:0]        sel_act_q, sel_act_d;
    // Marks that acc_q is the first value after a wrap, so sync_pulse lands on that sample
    logic              wrap_q, wrap_d;

    logic [ACC_W:0]    sum;
    logic              wrap;
    logic              load;
    logic [ACC_W-1:0]  phase;
    logic              phase_unused;
    logic [ADDR_W-1:0] addr_full;
    logic [ADDR_W-3:0] rom_addr_d;

    // S1 / S2 side information. P msb doubles as the sine half-cycle flag.
    logic [ADDR_W-3:0] rom_addr_q;
    logic [DATA_W:0]   s1_p_q, s2_p_q;
    logic [1:0]        s1_sel_q, s2_sel_q;
    logic              s1_en_q, s2_en_q;
    logic              s1_wrap_q, s2_wrap_q;

    // S3 output registers
    logic [DATA_W-1:0] wave_q, wave_d;
    logic              valid_q;
    logic              sync_q;

    // Next accumulator value, wrap detection and shadow-register load decision
    always_comb begin
        sum       = {1'b0, acc_q} + {1'b0, f_act_q};
        wrap      = dds.en & sum[ACC_W];
        // f_act==0 would never wrap, so it must keep reloading or 0 Hz locks forever
        load      = ~dds.en | wrap | (f_act_q == '0);
        acc_d     = dds.en ? sum[ACC_W-1:0] : '0;
        wrap_d    = wrap;
        f_act_d   = load ? dds.f_word   : f_act_q;
        p_act_d   = load ? dds.p_word   : p_act_q;
        sel_act_d = load ? dds.wave_sel : sel_act_q;
    end

    // Accumulator and shadow parameter state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            f_act_q   <= '0;
            p_act_q   <= '0;
            sel_act_q <= '0;
            wrap_q    <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            f_act_q   <= f_act_d;
            p_act_q   <= p_act_d;
            sel_act_q <= sel_act_d;
            wrap_q    <= wrap_d;
        end
    end

    // Phase word and quarter-wave folding: odd quadrants read the table backwards
    always_comb begin
        phase        = acc_q + p_act_q;
        phase_unused = ^phase;
        addr_full    = phase[ACC_W-1 -: ADDR_W];
        rom_addr_d   = addr_full[ADDR_W-2] ? ~addr_full[ADDR_W-3:0] : addr_full[ADDR_W-3:0];
    end

    // S1: register ROM address and the phase/mode info the output stage needs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr_q <= '0;
            s1_p_q     <= '0;
            s1_sel_q   <= '0;
            s1_en_q    <= 1'b0;
            s1_wrap_q  <= 1'b0;
        end else begin
            rom_addr_q <= rom_addr_d;
            s1_p_q     <= phase[ACC_W-1 -: DATA_W+1];
            s1_sel_q   <= sel_act_q;
            s1_en_q    <= dds.en;
            s1_wrap_q  <= wrap_q;
        end
    end

    // S2: delay side info by the ROM read latency so it lines up with rom_data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_p_q    <= '0;
            s2_sel_q  <= '0;
            s2_en_q   <= 1'b0;
            s2_wrap_q <= 1'b0;
        end else begin
            s2_p_q    <= s1_p_q;
            s2_sel_q  <= s1_sel_q;
            s2_en_q   <= s1_en_q;
            s2_wrap_q <= s1_wrap_q;
        end
    end

    // Waveform shaping from the aligned phase bits and ROM magnitude
    always_comb begin
        wave_d = s2_p_q[DATA_W:1];
        case (s2_sel_q)
            2'b00: wave_d = s2_p_q[DATA_W] ? (MID - ONE - {1'b0, dds.rom_data})
                                           : (MID + {1'b0, dds.rom_data});
            2'b01: wave_d = s2_p_q[DATA_W] ? '0 : '1;
            2'b10: wave_d = s2_p_q[DATA_W] ? ~s2_p_q[DATA_W-1:0] : s2_p_q[DATA_W-1:0];
            2'b11: wave_d = s2_p_q[DATA_W:1];
        endcase
    end

    // S3: registered sample, valid and sync outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wave_q  <= MID;
            valid_q <= 1'b0;
            sync_q  <= 1'b0;
        end else begin
            wave_q  <= wave_d;
            valid_q <= s2_en_q;
            sync_q  <= s2_wrap_q;
        end
    end

    assign dds.rom_addr   = rom_addr_q;
    assign dds.wave_out   = wave_q;
    assign dds.wave_valid = valid_q;
    assign dds.sync_pulse = sync_q;

endmodule

// File: tb/tb_dds_phase_gen.sv
// Self-checking bench for dds_phase_gen with a behavioural phase/sample model.
// Model output tracks the DUT cycle by cycle through a 3-sample delay line.
// No backpressure exists; every clock is compared.
module tb_dds_phase_gen;

    localparam real PI = 3.14159265358979;

    typedef struct packed {
        logic [7:0] out;
        logic       known;
        logic       vld;
        logic       syn;
    } samp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [31:0] f_word;
    logic [31:0] p_word;
    logic [1:0]  wave_sel;
    logic [6:0]  rom [256];
    logic [6:0]  rom_q = '0;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] rec_a [1024];
    logic [7:0] rec_b [1024];

    always #5 clk = ~clk;

    dds_phase_gen_if #(.ACC_W(32), .ADDR_W(10), .DATA_W(8)) dif ();

    dds_phase_gen #(.ACC_W(32), .ADDR_W(10), .DATA_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dds   (dif)
    );

    assign dif.en       = en;
    assign dif.f_word   = f_word;
    assign dif.p_word   = p_word;
    assign dif.wave_sel = wave_sel;
    assign dif.rom_data = rom_q;

    // Synchronous quarter-wave ROM
    always @(posedge clk) rom_q <= rom[dif.rom_addr];

    // ---------------- reference model ----------------
    function automatic logic [7:0] ref_addr(input logic [31:0] ph);
        int a, idx;
        a   = int'(ph >> 22);
        idx = a % 256;
        if ((a / 256) % 2 == 1) idx = 255 - idx;
        return 8'(idx);
    endfunction

    function automatic samp_t mk(input logic [31:0] ph, input logic [1:0] sel,
                                 input logic v, input logic s);
        samp_t r;
        int mag, t;
        r.known = 1'b1;
        r.vld   = v;
        r.syn   = s;
        mag     = int'(rom[ref_addr(ph)]);
        t       = int'((ph >> 23) % 256);
        case (sel)
            2'd0:    r.out = (ph < 32'h8000_0000) ? 8'(128 + mag) : 8'(127 - mag);
            2'd1:    r.out = (ph < 32'h8000_0000) ? 8'd255 : 8'd0;
            2'd2:    r.out = (ph < 32'h8000_0000) ? 8'(t) : 8'(255 - t);
            default: r.out = 8'(ph >> 24);
        endcase
        return r;
    endfunction

    logic [31:0] m_acc, m_f, m_p;
    logic [1:0]  m_sel;
    logic        m_wrapq;
    logic [32:0] m_sum;
    logic        m_wr, m_ld;
    samp_t       m_pipe0, m_pipe1, exp_s;
    logic [7:0]  exp_addr;

    assign m_sum = {1'b0, m_acc} + {1'b0, m_f};
    assign m_wr  = en & m_sum[32];
    assign m_ld  = ~en | m_wr | (m_f == 32'd0);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_acc    <= '0;
            m_f      <= '0;
            m_p      <= '0;
            m_sel    <= '0;
            m_wrapq  <= 1'b0;
            exp_s    <= '{out: 8'd128, known: 1'b1, vld: 1'b0, syn: 1'b0};
            m_pipe1  <= '{out: 8'd0, known: 1'b0, vld: 1'b0, syn: 1'b0};
            m_pipe0  <= mk(32'd0, 2'd0, 1'b0, 1'b0);
            exp_addr <= '0;
        end else begin
            exp_s    <= m_pipe1;
            m_pipe1  <= m_pipe0;
            m_pipe0  <= mk(m_acc + m_p, m_sel, en, m_wrapq);
            exp_addr <= ref_addr(m_acc + m_p);
            m_acc    <= en ? m_sum[31:0] : 32'd0;
            m_wrapq  <= m_wr;
            if (m_ld) begin
                m_f   <= f_word;
                m_p   <= p_word;
                m_sel <= wave_sel;
            end
        end
    end

    // Load new words with en=0, then start the accumulator from 0.
    task automatic configure(input logic [31:0] f, input logic [31:0] p, input logic [1:0] s);
        @(negedge clk);
        en       = 1'b0;
        f_word   = f;
        p_word   = p;
        wave_sel = s;
        repeat (4) @(negedge clk);
        en = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst_n = 1'b0; en = 1'b0; f_word = '0; p_word = '0; wave_sel = '0;
        repeat (2) @(negedge clk);
        n_cmp++; if (dif.wave_out !== 8'd128) begin n_bad++; $display("FAIL reset_wave got=%0d want=128", dif.wave_out); end
        n_cmp++; if (dif.wave_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b want=0", dif.wave_valid); end
        n_cmp++; if (dif.sync_pulse !== 1'b0) begin n_bad++; $display("FAIL reset_sync got=%b want=0", dif.sync_pulse); end
        n_cmp++; if (dif.rom_addr !== 8'd0) begin n_bad++; $display("FAIL reset_addr got=%0d want=0", dif.rom_addr); end
        rst_n = 1'b1;
    endtask

    task automatic test_sawtooth;
        int last, nsync;
        last = 0; nsync = 0;
        configure(32'h0040_0000, 32'd0, 2'd3);
        for (int k = 1; k <= 2200; k++) begin
            @(negedge clk);
            n_cmp++; if (dif.wave_out !== exp_s.out || dif.wave_valid !== exp_s.vld || dif.sync_pulse !== exp_s.syn) begin
                n_bad++; $display("FAIL saw_model k=%0d got=%0d/%b/%b want=%0d/%b/%b", k, dif.wave_out, dif.wave_valid, dif.sync_pulse, exp_s.out, exp_s.vld, exp_s.syn); end
            if (k >= 3) begin
                n_cmp++; if (dif.wave_out !== 8'(((k - 3) / 4) % 256)) begin
                    n_bad++; $display("FAIL saw_ramp k=%0d got=%0d want=%0d", k, dif.wave_out, ((k - 3) / 4) % 256); end
            end
            if (dif.sync_pulse === 1'b1) begin
                if (last > 0) begin
                    n_cmp++; if (k - last !== 1024) begin n_bad++; $display("FAIL saw_sync_period got=%0d want=1024", k - last); end
                end
                last = k; nsync++;
            end
        end
        n_cmp++; if (nsync !== 2) begin n_bad++; $display("FAIL saw_sync_count got=%0d want=2", nsync); end
    endtask

    task automatic test_sine;
        int j;
        configure(32'h0040_0000, 32'd0, 2'd0);
        for (int k = 1; k <= 1100; k++) begin
            @(negedge clk);
            n_cmp++; if (dif.wave_out !== exp_s.out || dif.wave_valid !== exp_s.vld || dif.sync_pulse !== exp_s.syn) begin
                n_bad++; $display("FAIL sine_model k=%0d got=%0d/%b/%b want=%0d/%b/%b", k, dif.wave_out, dif.wave_valid, dif.sync_pulse, exp_s.out, exp_s.vld, exp_s.syn); end
            n_cmp++; if (dif.rom_addr !== exp_addr) begin
                n_bad++; $display("FAIL sine_addr_model k=%0d got=%0d want=%0d", k, dif.rom_addr, exp_addr); end
            if (k <= 512) begin
                j = k - 1;
                n_cmp++; if (dif.rom_addr !== 8'((j < 256) ? j : 511 - j)) begin
                    n_bad++; $display("FAIL sine_addr_sweep k=%0d got=%0d want=%0d", k, dif.rom_addr, (j < 256) ? j : 511 - j); end
            end
            if (k == 2) begin
                n_cmp++; if (dif.wave_valid !== 1'b0) begin n_bad++; $display("FAIL sine_valid_early got=%b want=0", dif.wave_valid); end
            end
            if (k == 3) begin
                n_cmp++; if (dif.wave_valid !== 1'b1) begin n_bad++; $display("FAIL sine_valid_first got=%b want=1", dif.wave_valid); end
                n_cmp++; if (dif.wave_out !== 8'd128) begin n_bad++; $display("FAIL sine_sample0 got=%0d want=128", dif.wave_out); end
            end
            if (k == 258) begin
                n_cmp++; if (dif.wave_out !== 8'd255) begin n_bad++; $display("FAIL sine_peak got=%0d want=255", dif.wave_out); end
            end
        end
    endtask

    task automatic test_freq_change;
        int first, second;
        first = 0; second = 0;
        configure(32'h0040_0000, 32'd0, 2'd3);
        for (int k = 1; k <= 1800; k++) begin
            @(negedge clk);
            if (k == 300) f_word = 32'h0080_0000;
            n_cmp++; if (dif.wave_out !== exp_s.out || dif.wave_valid !== exp_s.vld || dif.sync_pulse !== exp_s.syn) begin
                n_bad++; $display("FAIL fchg_model k=%0d got=%0d/%b/%b want=%0d/%b/%b", k, dif.wave_out, dif.wave_valid, dif.sync_pulse, exp_s.out, exp_s.vld, exp_s.syn); end
            if (k == 700) begin
                n_cmp++; if (dif.wave_out !== 8'd174) begin n_bad++; $display("FAIL fchg_old_rate got=%0d want=174", dif.wave_out); end
            end
            if (k == 1047) begin
                n_cmp++; if (dif.wave_out !== 8'd10) begin n_bad++; $display("FAIL fchg_new_rate got=%0d want=10", dif.wave_out); end
            end
            if (dif.sync_pulse === 1'b1) begin
                if (first == 0) first = k;
                else if (second == 0) second = k;
            end
        end
        n_cmp++; if (first !== 1027) begin n_bad++; $display("FAIL fchg_wrap1 got=%0d want=1027", first); end
        n_cmp++; if (second !== 1539) begin n_bad++; $display("FAIL fchg_wrap2 got=%0d want=1539", second); end
        f_word = 32'h0040_0000;
    endtask

    task automatic test_zero_freq;
        configure(32'd0, 32'd0, 2'd3);
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 10) f_word = 32'h0040_0000;
            n_cmp++; if (dif.wave_out !== exp_s.out || dif.wave_valid !== exp_s.vld || dif.sync_pulse !== exp_s.syn) begin
                n_bad++; $display("FAIL zero_model k=%0d got=%0d/%b/%b want=%0d/%b/%b", k, dif.wave_out, dif.wave_valid, dif.sync_pulse, exp_s.out, exp_s.vld, exp_s.syn); end
            if (k == 12) begin
                n_cmp++; if (dif.wave_out !== 8'd0) begin n_bad++; $display("FAIL zero_hold got=%0d want=0", dif.wave_out); end
            end
            if (k == 54) begin
                n_cmp++; if (dif.wave_out !== 8'd10) begin n_bad++; $display("FAIL zero_start got=%0d want=10", dif.wave_out); end
            end
        end
    endtask

    task automatic test_phase_offset;
        // square: half-cycle offset gives exact complements
        configure(32'h0040_0000, 32'd0, 2'd1);
        for (int k = 1; k <= 1026; k++) begin @(negedge clk); if (k >= 3) rec_a[k-3] = dif.wave_out; end
        configure(32'h0040_0000, 32'h8000_0000, 2'd1);
        for (int k = 1; k <= 1026; k++) begin
            @(negedge clk);
            n_cmp++; if (dif.wave_out !== exp_s.out) begin n_bad++; $display("FAIL sq_model k=%0d got=%0d want=%0d", k, dif.wave_out, exp_s.out); end
            if (k >= 3) rec_b[k-3] = dif.wave_out;
        end
        for (int j = 0; j < 1024; j += 8) begin
            n_cmp++; if (rec_b[j] !== ~rec_a[j]) begin n_bad++; $display("FAIL sq_complement j=%0d got=%0d want=%0d", j, rec_b[j], ~rec_a[j]); end
        end
        // sine: quarter-cycle offset leads by 256 samples
        configure(32'h0040_0000, 32'd0, 2'd0);
        for (int k = 1; k <= 1026; k++) begin @(negedge clk); if (k >= 3) rec_a[k-3] = dif.wave_out; end
        configure(32'h0040_0000, 32'h4000_0000, 2'd0);
        for (int k = 1; k <= 770; k++) begin
            @(negedge clk);
            n_cmp++; if (dif.wave_out !== exp_s.out) begin n_bad++; $display("FAIL sin90_model k=%0d got=%0d want=%0d", k, dif.wave_out, exp_s.out); end
            if (k >= 3) rec_b[k-3] = dif.wave_out;
        end
        for (int j = 0; j < 768; j += 6) begin
            n_cmp++; if (rec_b[j] !== rec_a[j+256]) begin n_bad++; $display("FAIL sin_lead j=%0d got=%0d want=%0d", j, rec_b[j], rec_a[j+256]); end
        end
    endtask

    task automatic test_en_drop_and_reset;
        configure(32'h0040_0000, 32'd0, 2'd3);
        repeat (500) @(negedge clk);
        en = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            n_cmp++; if (dif.wave_valid !== ((k < 3) ? 1'b1 : 1'b0)) begin
                n_bad++; $display("FAIL endrop_valid k=%0d got=%b want=%b", k, dif.wave_valid, (k < 3)); end
            if (k >= 4) begin
                n_cmp++; if (dif.wave_out !== 8'd0) begin n_bad++; $display("FAIL endrop_acc0 k=%0d got=%0d want=0", k, dif.wave_out); end
            end
        end
        en = 1'b1;
        repeat (300) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (dif.wave_out !== 8'd128) begin n_bad++; $display("FAIL arst_wave got=%0d want=128", dif.wave_out); end
        n_cmp++; if (dif.wave_valid !== 1'b0) begin n_bad++; $display("FAIL arst_valid got=%b want=0", dif.wave_valid); end
        n_cmp++; if (dif.sync_pulse !== 1'b0) begin n_bad++; $display("FAIL arst_sync got=%b want=0", dif.sync_pulse); end
        n_cmp++; if (dif.rom_addr !== 8'd0) begin n_bad++; $display("FAIL arst_addr got=%0d want=0", dif.rom_addr); end
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (exp_s.known) begin
                n_cmp++; if (dif.wave_out !== exp_s.out) begin n_bad++; $display("FAIL post_rst_model k=%0d got=%0d want=%0d", k, dif.wave_out, exp_s.out); end
            end
            n_cmp++; if (dif.wave_valid !== 1'b0) begin n_bad++; $display("FAIL post_rst_valid k=%0d got=%b want=0", k, dif.wave_valid); end
            if (k >= 6) begin
                n_cmp++; if (dif.wave_out !== 8'd0) begin n_bad++; $display("FAIL post_rst_acc0 k=%0d got=%0d want=0", k, dif.wave_out); end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++)
            rom[i] = 7'($rtoi(127.0 * $sin(2.0 * PI * real'(i) / 1024.0) + 0.5));
        test_reset;
        test_sawtooth;
        test_sine;
        test_freq_change;
        test_zero_freq;
        test_phase_offset;
        test_en_drop_and_reset;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
